// File: rtl/spmv_row_accumulator_if.sv
// Beat input and result output bundle for the SpMV row accumulator.
// The master side is the gather stage plus result consumer; the slave side is the accumulator.
interface spmv_row_accumulator_if #(
  parameter int no_of_elements_in_output     = 8,
  parameter int element_width                = 32,
  parameter int multiples_memory_value_width = 32,
  parameter int row_index_width              = 16
);
  logic                                              you_can_read;
  logic [no_of_elements_in_output*element_width-1:0] output_row;
  logic [no_of_elements_in_output*element_width-1:0] matrix_row;
  logic [multiples_memory_value_width-1:0]           no_of_multiples;
  logic                                              result_ready;
  logic [element_width-1:0]                          row_result;
  logic [row_index_width-1:0]                        row_index;
  logic                                              result_valid;

  modport master (
    output you_can_read, output_row, matrix_row, no_of_multiples, result_ready,
    input  row_result, row_index, result_valid
  );

  modport slave (
    input  you_can_read, output_row, matrix_row, no_of_multiples, result_ready,
    output row_result, row_index, result_valid
  );
endinterface

// File: rtl/spmv_row_accumulator.sv
// Lane-wise multiply, adder tree and per-row accumulation with saturation,
// emitting one result per matrix row through a 2-entry ready/valid queue.
module spmv_row_accumulator #(
  parameter int no_of_elements_in_output     = 8,
  parameter int element_width                = 32,
  parameter int frac_bits                    = 16,
  parameter int acc_width                    = 72,
  parameter int multiples_memory_value_width = 32,
  parameter int row_index_width              = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  spmv_row_accumulator_if.slave  bus,
  output logic                   busy,
  output logic                   overflow,
  output logic                   saturated
);
  localparam int LANES = no_of_elements_in_output;
  localparam int EW    = element_width;
  localparam int PW    = 2 * element_width;
  localparam int AW    = acc_width;
  localparam int MW    = multiples_memory_value_width;
  localparam int RW    = row_index_width;

  // beats_left == 0 means the next accepted beat opens a new row
  logic [MW-1:0] beats_left;
  logic [MW-1:0] eff_mult;
  logic          first_beat;
  logic          last_beat;

  always_comb begin
    eff_mult   = (bus.no_of_multiples == '0) ? MW'(1) : bus.no_of_multiples;
    first_beat = (beats_left == '0);
    last_beat  = first_beat ? (eff_mult == MW'(1)) : (beats_left == MW'(2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      beats_left <= '0;
    else if (bus.you_can_read)
      beats_left <= last_beat ? '0 : (first_beat ? eff_mult : beats_left - MW'(1));
  end

  // stage 1: lane products
  logic                 v1, first1, last1;
  logic signed [PW-1:0] prod_s1 [LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
    end else begin
      v1     <= bus.you_can_read;
      first1 <= bus.you_can_read && first_beat;
      last1  <= bus.you_can_read && last_beat;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++)
      prod_s1[k] <= $signed(bus.output_row[k*EW +: EW]) * $signed(bus.matrix_row[k*EW +: EW]);
  end

  // stage 2: reduction
  logic signed [AW-1:0] tree_sum;
  logic signed [AW-1:0] sum_s2;
  logic                 v2, first2, last2;

  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < LANES; k++)
      tree_sum = tree_sum + AW'(prod_s1[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2     <= 1'b0;
      first2 <= 1'b0;
      last2  <= 1'b0;
      sum_s2 <= '0;
    end else begin
      v2     <= v1;
      first2 <= first1;
      last2  <= last1;
      sum_s2 <= tree_sum;
    end
  end

  // stage 3: accumulator; last3 marks that acc holds a finished row
  logic signed [AW-1:0] acc;
  logic                 last3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      last3 <= 1'b0;
    end else begin
      last3 <= v2 && last2;
      if (v2)
        acc <= (first2 ? '0 : acc) + sum_s2;
    end
  end

  logic signed [AW-1:0] shifted;
  logic [AW-EW:0]       upper;
  logic                 clip_pos, clip_neg;
  logic [EW-1:0]        sat_result;

  always_comb begin
    shifted    = acc >>> frac_bits;
    upper      = shifted[AW-1:EW-1];
    clip_pos   = !shifted[AW-1] && (|upper);
    clip_neg   = shifted[AW-1] && !(&upper);
    sat_result = shifted[EW-1:0];
    if (clip_pos)
      sat_result = {1'b0, {(EW-1){1'b1}}};
    else if (clip_neg)
      sat_result = {1'b1, {(EW-1){1'b0}}};
  end

  // result queue, entry 0 is the head
  logic [EW-1:0] q_data [2];
  logic [RW-1:0] q_idx  [2];
  logic [1:0]    q_count;
  logic [RW-1:0] row_cnt;
  logic          push, pop;

  assign push = last3;
  assign pop  = (q_count != 2'd0) && bus.result_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data[0] <= '0;
      q_data[1] <= '0;
      q_idx[0]  <= '0;
      q_idx[1]  <= '0;
      q_count   <= 2'd0;
      row_cnt   <= '0;
      overflow  <= 1'b0;
      saturated <= 1'b0;
    end else begin
      if (push) begin
        row_cnt <= row_cnt + RW'(1);
        if (clip_pos || clip_neg)
          saturated <= 1'b1;
        if (q_count == 2'd2 && !pop)
          overflow <= 1'b1;
      end
      if (push && pop) begin
        if (q_count == 2'd2) begin
          q_data[0] <= q_data[1];
          q_idx[0]  <= q_idx[1];
          q_data[1] <= sat_result;
          q_idx[1]  <= row_cnt;
        end else begin
          q_data[0] <= sat_result;
          q_idx[0]  <= row_cnt;
        end
      end else if (pop) begin
        q_data[0] <= q_data[1];
        q_idx[0]  <= q_idx[1];
        q_count   <= q_count - 2'd1;
      end else if (push && q_count != 2'd2) begin
        if (q_count == 2'd0) begin
          q_data[0] <= sat_result;
          q_idx[0]  <= row_cnt;
        end else begin
          q_data[1] <= sat_result;
          q_idx[1]  <= row_cnt;
        end
        q_count <= q_count + 2'd1;
      end
    end
  end

  assign bus.row_result   = q_data[0];
  assign bus.row_index    = q_idx[0];
  assign bus.result_valid = (q_count != 2'd0);
  assign busy             = (beats_left != '0) || v1 || v2 || last3;
endmodule

// File: doc/spmv_row_accumulator.md
# spmv_row_accumulator

Downstream consumer of the column-gather stage (`P_Emap_8`) in the sparse matrix-vector product datapath. Each beat pairs 8 gathered vector elements (`output_row`, qualified by `you_can_read`) with the 8 aligned nonzero matrix values of the same row. The block multiplies them lane by lane, reduces them, and accumulates across `no_of_multiples` beats. It emits one saturated fixed-point dot product per matrix row, with its row index, through a 2-entry result queue that has a ready/valid handshake.

## Interface
- `no_of_elements_in_output`, 8: lanes per beat.
- `element_width`, 32: signed two's-complement lane width, Q(element_width-frac_bits).frac_bits.
- `frac_bits`, 16: fractional bits of operands and result.
- `acc_width`, 72: accumulator width; must be ≥ 2*element_width + clog2(lanes) + 5.
- `multiples_memory_value_width`, 32: width of `no_of_multiples`.
- `row_index_width`, 16: width of row counter/index.
- `clk`, in, 1: single clock, all state on rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `you_can_read`, in, 1: beat valid from gather stage; no backpressure toward it.
- `output_row`, in, lanes*element_width: gathered vector elements; lane k at bits [(k+1)*element_width-1 -: element_width].
- `matrix_row`, in, lanes*element_width: nonzero values, same lane packing; padding lanes carry 0.
- `no_of_multiples`, in, multiples_memory_value_width: beats in current row; sampled on the row's first beat.
- `result_ready`, in, 1: consumer accepts head result.
- `row_result`, out, element_width: saturated row dot product.
- `row_index`, out, row_index_width: row number of `row_result`, starting at 0.
- `result_valid`, out, 1: queue head valid.
- `busy`, out, 1: a row is partially accumulated or the pipeline is non-empty.
- `overflow`, out, 1: sticky; a result was dropped because the queue was full.
- `saturated`, out, 1: sticky; a result was clipped.

## Operation
- Beat accepted on every edge where `you_can_read`=1. No other qualifier applies.
- First beat of a row: latch `beats_left` = `no_of_multiples`. A value of 0 is treated as 1.
- Each later accepted beat decrements `beats_left`. The beat that brings it to 1 is tagged `last`.
- Stage 1: 8 signed products, each 2*element_width bits, Q.(2*frac_bits), registered together with the `last` tag.
- Stage 2: 8-input signed adder tree, sign-extended to acc_width, registered.
- Stage 3: accumulator. `acc` = (first beat of row ? 0 : `acc`) + stage-2 sum.
- Stage 3 on `last`:
  - Arithmetic shift `acc` right by `frac_bits` (truncate toward −inf).
  - Saturate to signed element_width: 0x7FFFFFFF / 0x80000000. Set `saturated` if clipped.
  - Push {result, row counter} into the queue, then increment the row counter (wraps modulo 2^row_index_width).
- Queue is 2 entries with head on the outputs. An entry pops on an edge where `result_valid`&&`result_ready`.
- Push and pop on the same edge are both performed; a full queue plus a simultaneous pop accepts the push.
- Push to a full queue with no pop: the new result is dropped, `overflow` is set, and the row counter still increments.
- Rows are back-to-back. The first beat of the next row may arrive the cycle after the last beat of the previous row, and the accumulator restart is exact.
- Reset:
  - `result_valid`, `busy`, `overflow`, `saturated`, `row_result`, `row_index` all go to 0.
  - Queue empties, pipeline tags clear, row counter and `beats_left` go to 0.
  - A partially accumulated row is discarded. The first beat after reset release starts row 0.

## Timing
- Last beat of a row sampled at edge E0. The result is pushed at E3, and `result_valid`=1 after E3 if the queue was empty (latency 3).
- Throughput: 1 beat/cycle sustained. Results are limited only by consumer drain.
- `busy` is 1 from the edge that accepts the first beat until the edge that pushes that row's result, and stays 1 while any later row is in flight.
- `row_result`/`row_index` are stable while `result_valid`=1 and `result_ready`=0.
- Sticky flags clear only on `rst`.

## Test plan
- Single row, `no_of_multiples`=1, all lanes 0x00010000×0x00020000 → `row_result`=0x00100000 (16.0), `row_index`=0, valid 3 cycles after the beat.
- Three-beat row then a back-to-back 1-beat row:
  - beats with lane0 = 1.0×1.0, 2.0×1.0, −0.5×1.0 (other lanes 0) → 0x00028000.
  - next row → `row_index`=1, and its accumulator shows no carry-over.
- `no_of_multiples`=0 with one beat (lanes 0x00030000×0x00010000 on lane 0 only) → treated as 1, result 0x00030000.
- Saturation: 8 lanes 0x7FFFFFFF×0x7FFFFFFF, 1 beat → 0x7FFFFFFF, `saturated`=1. All lanes 0x80000000×0x7FFFFFFF → 0x80000000.
- Backpressure: `result_ready`=0, four 1-beat rows → 2 queued (indices 0,1), `overflow`=1; raising `result_ready` drains 0 then 1, and the next row is index 4.
- Assert `rst` mid-row (after 2 of 3 beats) → all outputs 0 immediately; a fresh 1-beat row afterwards yields `row_index`=0 with only its own sum.
